// File: rtl/flag_cond_pkg.sv
// rtl/flag_cond_pkg.sv - shared condition codes, FSM states and status bit indices
package flag_cond_pkg;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_PE = 4'd9;
  localparam logic [3:0] COND_PO = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int ST_S  = 4;
  localparam int ST_ZR = 3;
  localparam int ST_CY = 2;
  localparam int ST_P  = 1;
  localparam int ST_V  = 0;

  typedef enum logic [1:0] {
    STATE_EMPTY  = 2'd0,
    STATE_LOADED = 2'd1,
    STATE_EVAL   = 2'd2
  } state_t;

endpackage

// File: rtl/flag_cond_eval.sv
// rtl/flag_cond_eval.sv - combinational branch-condition decoder over {S, ZR, CY, P, V}
module flag_cond_eval
  import flag_cond_pkg::*;
(
  input  logic [4:0] i_status,
  input  logic [3:0] i_cond_code,
  output logic       o_taken
);

  logic w_s, w_zr, w_cy, w_p, w_v;

  assign w_s  = i_status[ST_S];
  assign w_zr = i_status[ST_ZR];
  assign w_cy = i_status[ST_CY];
  assign w_p  = i_status[ST_P];
  assign w_v  = i_status[ST_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond_code)
      COND_AL: o_taken = 1'b1;
      COND_EQ: o_taken = w_zr;
      COND_NE: o_taken = !w_zr;
      COND_CS: o_taken = w_cy;
      COND_CC: o_taken = !w_cy;
      COND_MI: o_taken = w_s;
      COND_PL: o_taken = !w_s;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = !w_v;
      COND_PE: o_taken = w_p;
      COND_PO: o_taken = !w_p;
      COND_GE: o_taken = (w_s == w_v);
      COND_LT: o_taken = (w_s != w_v);
      COND_GT: o_taken = !w_zr && (w_s == w_v);
      COND_LE: o_taken = w_zr || (w_s != w_v);
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - ALU result/flag capture with condition query handshake
// Optional saturating V/CY event counters with FLAG_CNT_EN.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef FLAG_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_res_valid,
  output logic             o_res_ready,
  input  logic [WIDTH-1:0] i_res_z,
  input  logic             i_res_s,
  input  logic             i_res_zr,
  input  logic             i_res_cy,
  input  logic             i_res_p,
  input  logic             i_res_v,
  input  logic             i_cond_req,
  input  logic [3:0]       i_cond_code,
  output logic             o_cond_ack,
  output logic             o_cond_taken,
  output logic [WIDTH-1:0] o_last_z,
  output logic [4:0]       o_status,
  output logic             o_stat_valid,
  output logic             o_sticky_v,
  input  logic             i_clr_sticky
`ifdef FLAG_CNT_EN
  , output logic [CNT_W-1:0] o_v_count
  , output logic [CNT_W-1:0] o_cy_count
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_last_z;
  logic [4:0]       r_status;
  logic             r_stat_valid;
  logic             r_sticky_v;
  logic             r_cond_ack;
  logic             r_cond_taken;
  logic             w_cap;
  logic             w_taken;

  // Queries win over captures in LOADED; EVAL blocks captures so status stays frozen.
  assign o_res_ready = (r_state == STATE_EMPTY) ||
                       ((r_state == STATE_LOADED) && !i_cond_req);
  assign w_cap       = i_res_valid && o_res_ready;

  flag_cond_eval u_eval (
    .i_status    (r_status),
    .i_cond_code (i_cond_code),
    .o_taken     (w_taken)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= STATE_EMPTY;
      r_last_z     <= '0;
      r_status     <= '0;
      r_stat_valid <= 1'b0;
      r_sticky_v   <= 1'b0;
      r_cond_ack   <= 1'b0;
      r_cond_taken <= 1'b0;
    end else begin
      if (w_cap) begin
        r_last_z     <= i_res_z;
        r_status     <= {i_res_s, i_res_zr, i_res_cy, i_res_p, i_res_v};
        r_stat_valid <= 1'b1;
      end
      if (w_cap && i_res_v) begin
        r_sticky_v <= 1'b1;
      end else if (i_clr_sticky) begin
        r_sticky_v <= 1'b0;
      end
      case (r_state)
        STATE_EMPTY: begin
          r_cond_ack <= 1'b0;
          if (w_cap) r_state <= STATE_LOADED;
        end
        STATE_LOADED: begin
          if (i_cond_req) begin
            r_state      <= STATE_EVAL;
            r_cond_ack   <= 1'b1;
            r_cond_taken <= w_taken;
          end
        end
        STATE_EVAL: begin
          r_state    <= STATE_LOADED;
          r_cond_ack <= 1'b0;
        end
        default: begin
          r_state    <= STATE_EMPTY;
          r_cond_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLAG_CNT_EN
  logic [CNT_W-1:0] r_v_count;
  logic [CNT_W-1:0] r_cy_count;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Clear beats a coincident increment; counts saturate at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_sticky) begin
      r_v_count  <= '0;
      r_cy_count <= '0;
    end else begin
      if (w_cap && i_res_v && (r_v_count != '1))   r_v_count  <= r_v_count + CNT_ONE;
      if (w_cap && i_res_cy && (r_cy_count != '1)) r_cy_count <= r_cy_count + CNT_ONE;
    end
  end

  assign o_v_count  = r_v_count;
  assign o_cy_count = r_cy_count;
`endif

  assign o_last_z     = r_last_z;
  assign o_status     = r_status;
  assign o_stat_valid = r_stat_valid;
  assign o_sticky_v   = r_sticky_v;
  assign o_cond_ack   = r_cond_ack;
  assign o_cond_taken = r_cond_taken;

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - directed scoreboard bench for flag_cond_unit
module tb_flag_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_z;
  logic        res_s, res_zr, res_cy, res_p, res_v;
  logic        cond_req;
  logic [3:0]  cond_code;
  logic        cond_ack;
  logic        cond_taken;
  logic [15:0] last_z;
  logic [4:0]  status;
  logic        stat_valid;
  logic        sticky_v;
  logic        clr_sticky;
`ifdef FLAG_CNT_EN
  logic [1:0]  v_count;
  logic [1:0]  cy_count;
`endif

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  flag_cond_unit #(
    .WIDTH (16)
`ifdef FLAG_CNT_EN
    , .CNT_W (2)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_res_valid  (res_valid),
    .o_res_ready  (res_ready),
    .i_res_z      (res_z),
    .i_res_s      (res_s),
    .i_res_zr     (res_zr),
    .i_res_cy     (res_cy),
    .i_res_p      (res_p),
    .i_res_v      (res_v),
    .i_cond_req   (cond_req),
    .i_cond_code  (cond_code),
    .o_cond_ack   (cond_ack),
    .o_cond_taken (cond_taken),
    .o_last_z     (last_z),
    .o_status     (status),
    .o_stat_valid (stat_valid),
    .o_sticky_v   (sticky_v),
    .i_clr_sticky (clr_sticky)
`ifdef FLAG_CNT_EN
    , .o_v_count  (v_count)
    , .o_cy_count (cy_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [15:0] z, input logic s, input logic zr,
                         input logic cy, input logic p, input logic v);
    logic done;
    done = 1'b0;
    res_valid = 1'b1;
    res_z = z; res_s = s; res_zr = zr; res_cy = cy; res_p = p; res_v = v;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = res_ready;
      step();
    end
    res_valid = 1'b0;
    if (!done) check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic query(input logic [3:0] code, input logic expect_taken);
    logic got;
    got = 1'b0;
    exp_q.push_back(expect_taken);
    cond_code = code;
    cond_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (cond_ack) begin
        got = 1'b1;
        check($sformatf("taken_code%0d", code), {31'd0, cond_taken}, {31'd0, exp_q.pop_front()});
      end
    end
    cond_req = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    step();
    check("ack_one_cycle", {31'd0, cond_ack}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_z = '0;
    res_s = 0; res_zr = 0; res_cy = 0; res_p = 0; res_v = 0;
    cond_req = 1'b0; cond_code = '0; clr_sticky = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_ready",      {31'd0, res_ready},  32'd1);
    check("rst_stat_valid", {31'd0, stat_valid}, 32'd0);
    check("rst_sticky",     {31'd0, sticky_v},   32'd0);
    check("rst_status",     {27'd0, status},     32'd0);
    check("rst_last_z",     {16'd0, last_z},     32'd0);
    check("rst_ack",        {31'd0, cond_ack},   32'd0);
    check("rst_taken",      {31'd0, cond_taken}, 32'd0);

    capture(16'h0fff, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("cap1_last_z", {16'd0, last_z},    32'h0fff);
    check("cap1_status", {27'd0, status},    32'b00111);
    check("cap1_sticky", {31'd0, sticky_v},  32'd1);
    check("cap1_valid",  {31'd0, stat_valid}, 32'd1);
    query(4'd3, 1'b1);
    query(4'd11, 1'b0);

    capture(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cap2_status", {27'd0, status}, 32'b01000);
    query(4'd1, 1'b1);
    query(4'd2, 1'b0);
    query(4'd14, 1'b1);
    query(4'd13, 1'b0);
    query(4'd0, 1'b1);
    query(4'd15, 1'b0);
    check("cap2_sticky_held", {31'd0, sticky_v}, 32'd1);

    // Query pending in EMPTY until the first capture.
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_valid", {31'd0, stat_valid}, 32'd0);
    cond_code = 4'd5; cond_req = 1'b1;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("empty_no_ack", {31'd0, cond_ack}, 32'd0);
    end
    res_valid = 1'b1; res_z = 16'h8000;
    res_s = 1; res_zr = 0; res_cy = 0; res_p = 0; res_v = 0;
    step();
    res_valid = 1'b0;
    check("empty_cap_no_ack", {31'd0, cond_ack}, 32'd0);
    check("empty_cap_z", {16'd0, last_z}, 32'h8000);
    step();
    check("empty_late_ack", {31'd0, cond_ack}, 32'd1);
    check("empty_mi_taken", {31'd0, cond_taken}, {31'd0, exp_q.pop_front()});
    cond_req = 1'b0;
    step();

    // Query and result together in LOADED: query uses old status, result stalls.
    cond_code = 4'd5; cond_req = 1'b1;
    res_valid = 1'b1; res_z = 16'h1234;
    res_s = 0; res_zr = 0; res_cy = 0; res_p = 0; res_v = 0;
    #1;
    check("stall_ready0", {31'd0, res_ready}, 32'd0);
    step();
    check("stall_ack",    {31'd0, cond_ack},   32'd1);
    check("stall_taken",  {31'd0, cond_taken}, 32'd1);
    check("stall_ready1", {31'd0, res_ready},  32'd0);
    check("stall_old_z",  {16'd0, last_z},     32'h8000);
    cond_req = 1'b0;
    step();
    check("stall_ready2", {31'd0, res_ready}, 32'd1);
    step();
    res_valid = 1'b0;
    check("stall_new_z",  {16'd0, last_z}, 32'h1234);
    check("stall_new_st", {27'd0, status}, 32'd0);

    // Sticky: set beats a coincident clear, clear alone works.
    clr_sticky = 1'b1;
    capture(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sticky_set_wins", {31'd0, sticky_v}, 32'd1);
    step();
    clr_sticky = 1'b0;
    check("sticky_cleared", {31'd0, sticky_v}, 32'd0);

    // Reset during EVAL drops the ack.
    cond_code = 4'd0; cond_req = 1'b1;
    step();
    check("pre_rst_ack", {31'd0, cond_ack}, 32'd1);
    rst = 1'b1; cond_req = 1'b0;
    step();
    rst = 1'b0;
    check("rst_eval_ack",   {31'd0, cond_ack},  32'd0);
    check("rst_eval_ready", {31'd0, res_ready}, 32'd1);

`ifdef FLAG_CNT_EN
    for (int i = 0; i < 5; i++) capture(16'h00ff, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("cy_count_sat", {30'd0, cy_count}, 32'd3);
    check("v_count_zero", {30'd0, v_count},  32'd0);
    clr_sticky = 1'b1;
    capture(16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    clr_sticky = 1'b0;
    check("cnt_clr_wins", {30'd0, cy_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
# flag_cond_unit

Consumer end of the 16-bit ALU result/flag interface. Captures each ALU result word and its five flags (S, ZR, CY, P, V) under a valid/ready handshake into a status register. Answers branch-condition queries against the held status through a req/ack handshake, and keeps a sticky overflow bit. Sits between the ALU and the sequencer/branch logic.

## Interface
- WIDTH, 16, result word width
- CNT_W, 8, width of the flag event counters (used only with FLAG_CNT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- res_valid  in  1  ALU result and flags valid
- res_ready  out  1  unit can capture this cycle
- res_z  in  WIDTH  ALU result Z
- res_s, res_zr, res_cy, res_p, res_v  in  1 each  ALU flags
- cond_req  in  1  condition query request; held until cond_ack
- cond_code  in  4  condition to evaluate; stable while cond_req is high
- cond_ack  out  1  one-cycle query acknowledge
- cond_taken  out  1  condition result; valid while cond_ack=1
- last_z  out  WIDTH  last captured result
- status  out  5  {S, ZR, CY, P, V} of the last capture
- stat_valid  out  1  at least one result captured since reset
- sticky_v  out  1  set by any captured V=1
- clr_sticky  in  1  clear sticky_v
- v_count, cy_count  out  CNT_W each  present only with FLAG_CNT_EN

## Operation
- FSM states: EMPTY, LOADED, EVAL.
  - EMPTY: res_ready=1. cond_req is not accepted. A capture moves the FSM to LOADED.
  - LOADED: res_ready = !cond_req. cond_req=1 moves the FSM to EVAL, and queries have priority over captures. A capture with no cond_req stays in LOADED.
  - EVAL: res_ready=0, status is frozen, cond_ack=1. Unconditional move to LOADED.
- Capture occurs when res_valid && res_ready at a clock edge. It loads last_z, status and stat_valid=1.
- Condition codes:
  - 0 always, 1 EQ(ZR), 2 NE(!ZR)
  - 3 CS(CY), 4 CC(!CY)
  - 5 MI(S), 6 PL(!S)
  - 7 VS(V), 8 VC(!V)
  - 9 PE(P), 10 PO(!P)
  - 11 GE(S==V), 12 LT(S!=V)
  - 13 GT(!ZR && S==V), 14 LE(ZR || S!=V)
  - 15 never
- cond_taken is registered at the accept edge from status and cond_code.
- sticky_v: a capture with res_v=1 sets it; clr_sticky clears it. If both happen in the same cycle, set wins.
- Flags are stored as delivered. The unit does not recompute them from res_z.

## Timing
- Reset values after a reset edge:
  - State EMPTY.
  - res_ready=1.
  - cond_ack=0, cond_taken=0.
  - last_z=0, status=0, stat_valid=0, sticky_v=0.
  - Counters = 0.
- Capture latency: a capture at edge N makes the new last_z/status visible from cycle N+1.
- Query latency: accept at edge N puts cond_ack=1 for exactly the one cycle N..N+1. If cond_req is still high at edge N+1 it is ignored (state EVAL). A new query can be accepted at edge N+2 at the earliest, giving a throughput of one query per 2 cycles.
- A query issued while in EMPTY waits, unacknowledged, until the first capture. It is accepted at the earliest one cycle after that capture.
- A result presented while cond_req is high in LOADED stalls (res_ready=0) until the query completes.
- Reset during EVAL suppresses the pending ack. The requester must re-issue.

## Configuration
- FLAG_CNT_EN defined:
  - v_count and cy_count increment on each capture with res_v=1 and res_cy=1 respectively.
  - They saturate at all-ones.
  - clr_sticky also clears both counters; on a simultaneous increment and clear, clear wins.
- FLAG_CNT_EN undefined: the counter ports and their logic are absent.

## Structure
- Shared package flag_cond_pkg holds:
  - Condition-code localparams (COND_AL … COND_NV).
  - State enum/localparams.
  - Status bit indices (ST_S=4, ST_ZR=3, ST_CY=2, ST_P=1, ST_V=0).
- One sub-module, flag_cond_eval: combinational decoder taking status and cond_code to taken. It is reusable by the sequencer.

## Test plan
- Reset -> res_ready=1, stat_valid=0, sticky_v=0, status=0, cond_ack never asserted.
- Capture Z=16'h0fff, CY=1, S=0, ZR=0, P=1, V=1 -> next cycle last_z=0fff, status=5'b00111, sticky_v=1. Then query code 3 (CS) -> ack one cycle after accept, taken=1. Then query code 11 (GE) -> taken=0.
- Capture Z=16'h0000, ZR=1, all other flags 0 -> EQ taken=1, NE taken=0, LE taken=1, GT taken=0, codes 0/15 give 1/0.
- cond_req held high in EMPTY for 5 cycles, then capture Z=16'h8000, S=1 -> query accepted 1 cycle after capture, MI taken=1.
- In LOADED, assert cond_req and res_valid together -> res_ready=0 for 2 cycles, the query uses the old status, and the result is captured after the ack.
- clr_sticky with a simultaneous V=1 capture -> sticky_v remains 1. With FLAG_CNT_EN and CNT_W=2, 5 captures with CY=1 -> cy_count=3.
